// File: rtl/uart_rx_fifo.sv
// 16x-oversampling 8N1 UART receiver with a first-word-fall-through receive FIFO.
// Define UART_RX_PARITY_EN for 8E1 frames with a sticky parity_err output.
module uart_rx_fifo #(
  parameter int unsigned CLOCK_FREQ = 50000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [7:0]                    rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          overrun
`ifdef UART_RX_PARITY_EN
  ,
  output logic                          parity_err
`endif
);

  localparam int unsigned DIV_RAW = CLOCK_FREQ / (BAUD_RATE * 16);
  localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int unsigned TICK_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e              state_q, state_d;
  logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
  logic [3:0]          s_q, s_d;
  logic [2:0]          bit_q, bit_d;
  logic                rx_s1_q, rx_s1_d;
  logic                rx_s_q, rx_s_d;
  logic                rx_prev_q, rx_prev_d;
  logic [1:0]          smp_q, smp_d;
  logic                vote_q, vote_d;
  logic [7:0]          shift_q, shift_d;

  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                empty_q, empty_d;
  logic                full_q, full_d;
  logic [7:0]          rd_data_q, rd_data_d;
  logic [7:0]          mem_q [FIFO_DEPTH];
  logic [7:0]          mem_d [FIFO_DEPTH];
  logic                frame_err_q, frame_err_d;
  logic                overrun_q, overrun_d;

`ifdef UART_RX_PARITY_EN
  logic                par_bad_q, par_bad_d;
  logic                parity_err_q, parity_err_d;
`endif

  logic                tick_c;
  logic                vote_c;
  logic                stop_good_c;
  logic                stop_bad_c;
  logic                push_c;
  logic                pop_c;
  logic                ovr_set_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      tick_cnt_q   <= '0;
      s_q          <= '0;
      bit_q        <= '0;
      rx_s1_q      <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b1;
      smp_q        <= '0;
      vote_q       <= 1'b0;
      shift_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      rd_data_q    <= '0;
      mem_q        <= '{default: '0};
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      s_q          <= s_d;
      bit_q        <= bit_d;
      rx_s1_q      <= rx_s1_d;
      rx_s_q       <= rx_s_d;
      rx_prev_q    <= rx_prev_d;
      smp_q        <= smp_d;
      vote_q       <= vote_d;
      shift_q      <= shift_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
      rd_data_q    <= rd_data_d;
      mem_q        <= mem_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  // Synchronizer, oversample tick and receive FSM.
  always_comb begin
    rx_s1_d     = rx;
    rx_s_d      = rx_s1_q;
    rx_prev_d   = rx_s_q;
    state_d     = state_q;
    s_d         = s_q;
    bit_d       = bit_q;
    smp_d       = smp_q;
    vote_d      = vote_q;
    shift_d     = shift_q;
    stop_good_c = 1'b0;
    stop_bad_c  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d   = par_bad_q;
`endif

    tick_c     = (tick_cnt_q == TICK_W'(DIV - 1));
    tick_cnt_d = tick_c ? '0 : tick_cnt_q + TICK_W'(1);
    // Samples at s=7 and s=8 are stored; the s=9 sample is the live rx_s.
    vote_c     = (smp_q[1] & smp_q[0]) | (smp_q[1] & rx_s_q) | (smp_q[0] & rx_s_q);

    if (state_q == S_IDLE) begin
      if (rx_prev_q && !rx_s_q) begin
        state_d    = S_START;
        s_d        = '0;
        tick_cnt_d = '0;
      end
    end else if (tick_c) begin
      if (s_q == 4'd7 || s_q == 4'd8) begin
        smp_d = {smp_q[0], rx_s_q};
      end
      if (s_q == 4'd9) begin
        vote_d = vote_c;
      end
      s_d = s_q + 4'd1;

      case (state_q)
        S_START: begin
          if (s_q == 4'd15) begin
            if (!vote_q) begin
              state_d = S_DATA;
              bit_d   = '0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (s_q == 4'd15) begin
            shift_d = {vote_q, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (s_q == 4'd15) begin
            par_bad_d = (^shift_q) ^ vote_q;
            state_d   = S_STOP;
          end
        end
`endif
        // Stop bit is decided at mid-sample so a following start edge is not missed.
        S_STOP: begin
          if (s_q == 4'd9) begin
            state_d     = S_IDLE;
            s_d         = '0;
            stop_good_c = vote_c;
            stop_bad_c  = !vote_c;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Receive FIFO with registered first-word-fall-through head and sticky flags.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    mem_d     = mem_q;
    rd_data_d = rd_data_q;

    pop_c     = rd_en && !empty_q;
    push_c    = stop_good_c && (!full_q || pop_c);
    ovr_set_c = stop_good_c && full_q && !rd_en;

    if (push_c) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_W'(FIFO_DEPTH));

    if (empty_d) begin
      rd_data_d = '0;
    end else if (push_c && (rd_ptr_d == wr_ptr_q)) begin
      rd_data_d = shift_q;
    end else begin
      rd_data_d = mem_q[rd_ptr_d];
    end

    // Setting a flag wins over a simultaneous clear.
    frame_err_d = clr_err ? 1'b0 : frame_err_q;
    overrun_d   = clr_err ? 1'b0 : overrun_q;
    if (stop_bad_c) begin
      frame_err_d = 1'b1;
    end
    if (ovr_set_c) begin
      overrun_d = 1'b1;
    end
`ifdef UART_RX_PARITY_EN
    parity_err_d = clr_err ? 1'b0 : parity_err_q;
    if (stop_good_c && par_bad_q) begin
      parity_err_d = 1'b1;
    end
`endif
  end

  assign rd_data   = rd_data_q;
  assign empty     = empty_q;
  assign full      = full_q;
  assign count     = count_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule
